// File: rtl/alu_exec_if.sv
// Operation/result handshake bundle between the execute-stage issuer and alu_exec.
// The slave side is the ALU; the master side issues operations and consumes results.
interface alu_exec_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Multi-cycle integer ALU: single-cycle arithmetic/logic/compare, serial one-bit-per-cycle
// shifter, result/zero/illegal held on an output handshake until retired.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  alu_exec_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLT = 4'h5;
  localparam logic [3:0] OP_SLL = 4'h6;
  localparam logic [3:0] OP_SRL = 4'h7;
  localparam logic [3:0] OP_SRA = 4'h8;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic            is_shift;
  logic            shift_start;
  logic            shift_last;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] calc_res;
  logic            calc_ill;
  logic [XLEN-1:0] work_shifted;

  logic [3:0]      op_p0;
  logic [XLEN-1:0] work_p0;
  logic [SHW-1:0]  cnt_p0;
  logic [XLEN-1:0] result_p1;
  logic            zero_p1;
  logic            illegal_p1;

  // Shift codes land here only with a zero shift amount, where the result is A unchanged.
  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [XLEN-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:                 r = a + b;
      OP_SUB:                 r = a - b;
      OP_AND:                 r = a & b;
      OP_OR:                  r = a | b;
      OP_XOR:                 r = a ^ b;
      OP_SLT:                 r = {{(XLEN-1){1'b0}}, (sa < sb)};
      OP_SLL, OP_SRL, OP_SRA: r = a;
      default:                r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                input logic [XLEN-1:0] w);
    logic [XLEN-1:0] r;
    case (op)
      OP_SLL:  r = {w[XLEN-2:0], 1'b0};
      OP_SRL:  r = {1'b0, w[XLEN-1:1]};
      default: r = {w[XLEN-1], w[XLEN-1:1]};
    endcase
    return r;
  endfunction

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_p1;
  assign bus.zero      = zero_p1;
  assign bus.illegal   = illegal_p1;

  always_comb begin
    shamt        = bus.src_b[SHW-1:0];
    accept       = bus.in_valid && bus.in_ready;
    is_shift     = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL) ||
                   (bus.alu_control == OP_SRA);
    shift_start  = is_shift && (shamt != '0);
    calc_res     = alu_calc(bus.alu_control, bus.src_a, bus.src_b);
    calc_ill     = (bus.alu_control > OP_SRA);
    work_shifted = shift_one(op_p0, work_p0);
    shift_last   = (state == SHIFT) && (cnt_p0 == SHW'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_nxt = shift_start ? SHIFT : DONE;
        else if ((state == DONE) && bus.out_ready)
          state_nxt = IDLE;
      end
      SHIFT: begin
        if (shift_last)
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Stage p0: shifter working register and count; stage p1: registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_p0      <= '0;
      work_p0    <= '0;
      cnt_p0     <= '0;
      result_p1  <= '0;
      zero_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
    end else if (accept) begin
      if (shift_start) begin
        op_p0   <= bus.alu_control;
        work_p0 <= bus.src_a;
        cnt_p0  <= shamt;
      end else begin
        result_p1  <= calc_res;
        zero_p1    <= (calc_res == '0);
        illegal_p1 <= calc_ill;
      end
    end else if (state == SHIFT) begin
      work_p0 <= work_shifted;
      cnt_p0  <= cnt_p0 - SHW'(1);
      if (shift_last) begin
        result_p1  <= work_shifted;
        zero_p1    <= (work_shifted == '0);
        illegal_p1 <= 1'b0;
      end
    end
  end
endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle integer ALU execute unit: the consumer of the 4-bit ALU control code produced by the ALU decoder in the execute stage. It accepts an operation plus two operands over a valid/ready handshake. Add/sub/logic/compare ops finish in one cycle. Shifts run serially, one bit position per cycle, trading latency for area. The result, a zero flag and an illegal-op flag are held on an output handshake until the downstream stage (hazard/writeback logic) takes them.

## Interface
- XLEN, 32: operand and result width; shift amount field is log2(XLEN) bits (5 at default).
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept; transfer when in_valid & in_ready at the clk edge.
- alu_control  input  4  operation code, sampled on transfer.
- src_a  input  XLEN  operand A, sampled on transfer.
- src_b  input  XLEN  operand B; the low log2(XLEN) bits are the shift amount for shifts.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts; retire when out_valid & out_ready.
- result  output  XLEN  registered result.
- zero  output  1  registered, 1 when result == 0.
- illegal  output  1  registered, 1 when the accepted code was unassigned.

## Operation
- Codes:
  - 0000 add
  - 0001 sub (A−B)
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt (signed A<B gives 1, else 0)
  - 0110 sll
  - 0111 srl
  - 1000 sra
- Codes 1001–1111 are illegal: result=0, zero=1, illegal=1, single-cycle path.
- All arithmetic is modulo 2^XLEN. Carry and overflow are discarded. slt uses the signed comparison, not the sign of the subtraction.
- FSM states:
  - IDLE: in_ready=1. On transfer:
    - non-shift or illegal op: compute, register the result, go to DONE.
    - shift with shamt==0: result=src_a, go to DONE.
    - shift with shamt>0: load the working register with src_a and the counter with shamt, go to SHIFT.
  - SHIFT: each cycle shift the working register one bit and decrement the counter.
    - sll fills 0. srl fills 0. sra replicates the bit held in MSB.
    - When the counter reaches 1, that cycle's shifted value is registered as the result and the state goes to DONE.
    - in_ready=0. Input pins are ignored.
  - DONE: out_valid=1. result, zero and illegal stay stable until retired.
    - out_ready=0: remain in DONE.
    - out_ready=1 and no new transfer: go to IDLE.
    - out_ready=1 and in_valid=1: in_ready=1 (combinational from out_ready), so retire and accept in the same edge. Next state is chosen as in IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). No combinational path from in_valid to out_valid.
- zero and illegal are registered together with result and always correspond to it.

## Timing
- Reset (asserted, asynchronous):
  - state=IDLE, out_valid=0, result=0, zero=0, illegal=0.
  - Shift counter and working register cleared.
  - in_ready=1 while reset_n is high and the state is IDLE.
- Reset mid-SHIFT or mid-DONE: operation abandoned, no out_valid pulse, nothing is retired. The first edge after release can accept.
- Latency, measured from the transfer edge to out_valid high:
  - non-shift, illegal, or shift with shamt==0: 1 cycle.
  - shift: 1+shamt cycles. shamt=31 gives 32 cycles.
- Throughput with out_ready held high: one single-cycle op per clock (DONE overlaps accept). Shifts: one per 1+shamt cycles.
- Shift amount uses only src_b[log2(XLEN)-1:0]. Upper bits of src_b are ignored.
- Back-pressure: holding out_ready=0 for any number of cycles leaves all outputs unchanged and in_ready=0.

## Test plan
- After reset: in_ready=1, out_valid=0, result=0. Then add 0x7FFFFFFF + 0x00000001 → one cycle later out_valid=1, result=0x80000000, zero=0.
- sub 5−5 → result=0, zero=1. slt A=0xFFFFFFFF, B=0x00000001 → result=1. Codes 0010/0011/0100 on 0xF0F0F0F0, 0xFF00FF00 → 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0.
- sra A=0x80000000, B=0x0000001F → out_valid after exactly 32 cycles, result=0xFFFFFFFF. srl with the same operands → 0x00000001. sll A=1, B=0x00000024 (shamt 4) → 0x10, latency 5. Any shift with shamt 0 → latency 1, result=A.
- Streaming: 4 back-to-back adds with out_ready=1 and in_valid=1 every cycle → 4 transfers in 4 consecutive cycles, results in order. Then out_ready=0 for 3 cycles → result stable, in_ready=0.
- Code 1011 → illegal=1, result=0, zero=1, latency 1. The next legal op clears illegal.
- reset_n pulsed low during the 10th cycle of a 31-bit shift → out_valid never rises for that op, all outputs cleared. A new add is accepted on the first edge after release.
